// File: rtl/stark_fetch_ctrl_pkg.sv
// Shared constants, fetch-state encoding and branch-number helper for the
// Stark fetch-stage sequencer.
package stark_fetch_ctrl_pkg;

    localparam int          DEF_PCW        = 32;
    localparam logic [31:0] DEF_RSTPC      = 32'hFFFD_0000;
    localparam int          DEF_FETCH_INC  = 20;
    localparam int          DEF_LINE_BYTES = 128;
    localparam int          DEF_BNOW       = 5;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_RUN,
        ST_MISS
    } fetch_state_t;

    // Branch numbers run 1..2^w-1; zero is reserved, so the wrap lands on 1.
    function automatic logic [31:0] bno_inc(input logic [31:0] bno, input int w);
        logic [31:0] nxt;
        nxt = bno + 32'd1;
        if (nxt == 32'd0 || (w < 32 && nxt >= (32'd1 << w)))
            nxt = 32'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/stark_fetch_irq_latch.sv
// Interrupt request latch: captures a level above the current mask, raises it
// while pending, and clears on acknowledge from commit.
module stark_fetch_irq_latch
    import stark_fetch_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       mc_active_i,
    input  logic [5:0] irq_i,
    input  logic [5:0] irq_level_i,
    input  logic       irq_ack_i,
    output logic [5:0] irq_o,
    output logic       irqf_o
);

    logic [5:0] r_irq;
    logic       r_irqf;

    // Ack wins over a same-cycle set; a request still present re-sets next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_irq  <= 6'd0;
            r_irqf <= 1'b0;
        end else if (irq_ack_i) begin
            r_irq  <= 6'd0;
            r_irqf <= 1'b0;
        end else if (!r_irqf) begin
            if (irq_i > irq_level_i && !mc_active_i) begin
                r_irq  <= irq_i;
                r_irqf <= 1'b1;
            end
        end else if (irq_i > r_irq) begin
            r_irq <= irq_i;
        end
    end

    assign irq_o  = r_irq;
    assign irqf_o = r_irqf;

endmodule

// File: rtl/stark_fetch_ctrl.sv
// Fetch-stage sequencer: reset flush, sequential/predicted advance, branch-miss
// redirect, I-cache miss request/ack, stall and micro-code hold.
module stark_fetch_ctrl
    import stark_fetch_ctrl_pkg::*;
#(
    parameter int             PCW        = DEF_PCW,
    parameter logic [PCW-1:0] RSTPC      = PCW'(DEF_RSTPC),
    parameter int             FETCH_INC  = DEF_FETCH_INC,
    parameter int             LINE_BYTES = DEF_LINE_BYTES,
    parameter int             BNOW       = DEF_BNOW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ihit,
    input  logic            stall_i,
    input  logic            branchmiss_i,
    input  logic [PCW-1:0]  misspc_i,
    input  logic            predict_taken_i,
    input  logic [PCW-1:0]  predict_pc_i,
    input  logic            mc_active_i,
    input  logic            miss_ack_i,
    input  logic [5:0]      irq_i,
    input  logic [5:0]      irq_level_i,
    input  logic            irq_ack_i,
    output logic [PCW-1:0]  pc_o,
    output logic [BNOW-1:0] bno_o,
    output logic            en_o,
    output logic [2:0]      rstcnt_o,
    output logic            stomp_fet_o,
    output logic [BNOW-1:0] stomp_bno_o,
    output logic            miss_req_o,
    output logic [PCW-1:0]  miss_adr_o,
    output logic [5:0]      irq_o,
    output logic            irqf_o
);

    localparam logic [PCW-1:0] LINE_MASK = ~PCW'(LINE_BYTES - 1);
    localparam logic [PCW-1:0] PC_INC    = PCW'(FETCH_INC);

    fetch_state_t    r_state;
    logic [PCW-1:0]  r_pc;
    logic [BNOW-1:0] r_bno;
    logic            r_en;
    logic [2:0]      r_rstcnt;
    logic            r_stomp_fet;
    logic [BNOW-1:0] r_stomp_bno;
    logic            r_miss_req;
    logic [PCW-1:0]  r_miss_adr;
    logic [BNOW-1:0] w_bno_next;

    assign w_bno_next = BNOW'(bno_inc(32'(r_bno), BNOW));

    // NOTE: all state is updated with non-blocking assignments so every branch
    // below reads the pre-edge values (e.g. stomp_bno captures the old bno).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RESET;
            r_pc        <= RSTPC;
            r_bno       <= BNOW'(1);
            r_en        <= 1'b1;
            r_rstcnt    <= 3'd0;
            r_stomp_fet <= 1'b0;
            r_stomp_bno <= '0;
            r_miss_req  <= 1'b0;
            r_miss_adr  <= '0;
        end else begin
            r_stomp_fet <= 1'b0;

            // A branch miss redirects in both RUN and MISS; an open fill still completes.
            if (branchmiss_i && r_state != ST_RESET) begin
                r_pc        <= misspc_i;
                r_stomp_fet <= 1'b1;
                r_stomp_bno <= r_bno;
                r_bno       <= w_bno_next;
            end

            case (r_state)
                ST_RESET: begin
                    r_en <= 1'b1;
                    if (r_rstcnt == 3'd7)
                        r_state <= ST_RUN;
                    else
                        r_rstcnt <= r_rstcnt + 3'd1;
                end
                ST_RUN: begin
                    r_en <= !stall_i && ihit;
                    if (!branchmiss_i && !mc_active_i && !stall_i) begin
                        if (!ihit) begin
                            r_miss_req <= 1'b1;
                            r_miss_adr <= r_pc & LINE_MASK;
                            r_state    <= ST_MISS;
                        end else if (predict_taken_i) begin
                            r_pc  <= predict_pc_i;
                            r_bno <= w_bno_next;
                        end else begin
                            r_pc <= r_pc + PC_INC;
                        end
                    end
                end
                ST_MISS: begin
                    r_en <= 1'b0;
                    if (miss_ack_i) begin
                        r_miss_req <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end
                default: r_state <= ST_RESET;
            endcase
        end
    end

    stark_fetch_irq_latch u_irq (
        .clk         (clk),
        .rst         (rst),
        .mc_active_i (mc_active_i),
        .irq_i       (irq_i),
        .irq_level_i (irq_level_i),
        .irq_ack_i   (irq_ack_i),
        .irq_o       (irq_o),
        .irqf_o      (irqf_o)
    );

    assign pc_o        = r_pc;
    assign bno_o       = r_bno;
    assign en_o        = r_en;
    assign rstcnt_o    = r_rstcnt;
    assign stomp_fet_o = r_stomp_fet;
    assign stomp_bno_o = r_stomp_bno;
    assign miss_req_o  = r_miss_req;
    assign miss_adr_o  = r_miss_adr;

endmodule

// File: tb/tb_stark_fetch_ctrl.sv
// Scoreboard bench for stark_fetch_ctrl: directed scenarios then random stimulus,
// each cycle's expected outputs queued by the driver and compared by a monitor.
module tb_stark_fetch_ctrl;

    localparam logic [31:0] RSTPC = 32'hFFFD_0000;

    typedef struct {
        logic        ihit;
        logic        stall;
        logic        bm;
        logic [31:0] misspc;
        logic        pt;
        logic [31:0] ppc;
        logic        mc;
        logic        ack;
        logic [5:0]  irq;
        logic [5:0]  lvl;
        logic        iack;
    } in_t;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  bno;
        logic        en;
        logic [2:0]  rstcnt;
        logic        stomp_fet;
        logic [4:0]  stomp_bno;
        logic        miss_req;
        logic [31:0] miss_adr;
        logic [5:0]  irq;
        logic        irqf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ihit, stall_i, branchmiss_i, predict_taken_i, mc_active_i, miss_ack_i, irq_ack_i;
    logic [31:0] misspc_i, predict_pc_i;
    logic [5:0]  irq_i, irq_level_i;
    logic [31:0] pc_o, miss_adr_o;
    logic [4:0]  bno_o, stomp_bno_o;
    logic        en_o, stomp_fet_o, miss_req_o, irqf_o;
    logic [2:0]  rstcnt_o;
    logic [5:0]  irq_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    exp_t m_cur;
    int   m_mode;   // 0 = reset flush, 1 = run, 2 = waiting for line fill

    stark_fetch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .ihit            (ihit),
        .stall_i         (stall_i),
        .branchmiss_i    (branchmiss_i),
        .misspc_i        (misspc_i),
        .predict_taken_i (predict_taken_i),
        .predict_pc_i    (predict_pc_i),
        .mc_active_i     (mc_active_i),
        .miss_ack_i      (miss_ack_i),
        .irq_i           (irq_i),
        .irq_level_i     (irq_level_i),
        .irq_ack_i       (irq_ack_i),
        .pc_o            (pc_o),
        .bno_o           (bno_o),
        .en_o            (en_o),
        .rstcnt_o        (rstcnt_o),
        .stomp_fet_o     (stomp_fet_o),
        .stomp_bno_o     (stomp_bno_o),
        .miss_req_o      (miss_req_o),
        .miss_adr_o      (miss_adr_o),
        .irq_o           (irq_o),
        .irqf_o          (irqf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t idle_in();
        in_t s;
        s.ihit = 1'b1; s.stall = 1'b0; s.bm = 1'b0; s.misspc = '0;
        s.pt = 1'b0; s.ppc = '0; s.mc = 1'b0; s.ack = 1'b0;
        s.irq = '0; s.lvl = '0; s.iack = 1'b0;
        return s;
    endfunction

    function automatic in_t rand_in();
        in_t s;
        s.ihit   = ($urandom_range(0, 99) < 80);
        s.stall  = ($urandom_range(0, 99) < 15);
        s.bm     = ($urandom_range(0, 99) < 10);
        s.misspc = $urandom();
        s.pt     = ($urandom_range(0, 99) < 25);
        s.ppc    = $urandom();
        s.mc     = ($urandom_range(0, 99) < 10);
        s.ack    = ($urandom_range(0, 99) < 25);
        s.irq    = 6'($urandom_range(0, 7));
        s.lvl    = 6'($urandom_range(0, 5));
        s.iack   = ($urandom_range(0, 99) < 10);
        return s;
    endfunction

    function automatic logic [4:0] next_bno(input logic [4:0] b);
        return 5'((int'(b) % 31) + 1);
    endfunction

    task automatic model_reset();
        m_cur.pc = RSTPC; m_cur.bno = 5'd1; m_cur.en = 1'b1; m_cur.rstcnt = 3'd0;
        m_cur.stomp_fet = 1'b0; m_cur.stomp_bno = 5'd0; m_cur.miss_req = 1'b0;
        m_cur.miss_adr = 32'd0; m_cur.irq = 6'd0; m_cur.irqf = 1'b0;
        m_mode = 0;
    endtask

    // Reference model: one clock of the sequencer, derived from the fetch rules.
    task automatic model_step(input in_t s);
        exp_t n;
        int   mode_n;
        n = m_cur;
        mode_n = m_mode;
        n.stomp_fet = 1'b0;
        if (m_mode != 0 && s.bm) begin
            n.pc = s.misspc;
            n.stomp_fet = 1'b1;
            n.stomp_bno = m_cur.bno;
            n.bno = next_bno(m_cur.bno);
        end
        if (m_mode == 0) begin
            n.en = 1'b1;
            if (m_cur.rstcnt == 3'd7) mode_n = 1;
            else n.rstcnt = m_cur.rstcnt + 3'd1;
        end else if (m_mode == 1) begin
            n.en = !s.stall && s.ihit;
            if (s.bm || s.mc || s.stall) begin
                // redirect already applied, or fetch address held
            end else if (!s.ihit) begin
                n.miss_req = 1'b1;
                n.miss_adr = m_cur.pc - (m_cur.pc % 128);
                mode_n = 2;
            end else if (s.pt) begin
                n.pc = s.ppc;
                n.bno = next_bno(m_cur.bno);
            end else begin
                n.pc = m_cur.pc + 32'd20;
            end
        end else begin
            n.en = 1'b0;
            if (s.ack) begin
                n.miss_req = 1'b0;
                mode_n = 1;
            end
        end
        if (s.iack) begin
            n.irqf = 1'b0;
            n.irq = 6'd0;
        end else if (!m_cur.irqf && s.irq > s.lvl && !s.mc) begin
            n.irqf = 1'b1;
            n.irq = s.irq;
        end else if (m_cur.irqf && s.irq > m_cur.irq) begin
            n.irq = s.irq;
        end
        m_cur = n;
        m_mode = mode_n;
    endtask

    task automatic apply(input in_t s);
        ihit = s.ihit; stall_i = s.stall; branchmiss_i = s.bm; misspc_i = s.misspc;
        predict_taken_i = s.pt; predict_pc_i = s.ppc; mc_active_i = s.mc;
        miss_ack_i = s.ack; irq_i = s.irq; irq_level_i = s.lvl; irq_ack_i = s.iack;
    endtask

    task automatic cycle(input in_t s);
        @(negedge clk);
        apply(s);
        model_step(s);
        sb_q.push_back(m_cur);
    endtask

    task automatic sample();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("pc",        pc_o,               e.pc);
            check("bno",       32'(bno_o),         32'(e.bno));
            check("en",        32'(en_o),          32'(e.en));
            check("rstcnt",    32'(rstcnt_o),      32'(e.rstcnt));
            check("stomp_fet", 32'(stomp_fet_o),   32'(e.stomp_fet));
            check("stomp_bno", 32'(stomp_bno_o),   32'(e.stomp_bno));
            check("miss_req",  32'(miss_req_o),    32'(e.miss_req));
            check("miss_adr",  miss_adr_o,         e.miss_adr);
            check("irq",       32'(irq_o),         32'(e.irq));
            check("irqf",      32'(irqf_o),        32'(e.irqf));
        end
    end

    initial begin
        in_t s;
        rst = 1'b1;
        apply(idle_in());
        model_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_pc", pc_o, RSTPC);
        check("rst_bno", 32'(bno_o), 32'd1);
        check("rst_en", 32'(en_o), 32'd1);
        check("rst_rstcnt", 32'(rstcnt_o), 32'd0);
        check("rst_miss_req", 32'(miss_req_o), 32'd0);
        sample();
        rst = 1'b1;

        // Reset flush then two sequential groups.
        repeat (10) cycle(idle_in());
        sample();
        check("run_pc_plus40", pc_o, RSTPC + 32'd40);
        check("run_rstcnt", 32'(rstcnt_o), 32'd7);

        // Redirect to 0x1234, then miss there.
        s = idle_in(); s.bm = 1'b1; s.misspc = 32'h1234;
        cycle(s);
        sample();
        check("bm_stomp", 32'(stomp_fet_o), 32'd1);
        s = idle_in(); s.ihit = 1'b0;
        cycle(s);
        sample();
        check("miss_req_set", 32'(miss_req_o), 32'd1);
        check("miss_adr_line", miss_adr_o, 32'h1200);
        check("miss_en", 32'(en_o), 32'd0);
        repeat (5) cycle(idle_in());
        s = idle_in(); s.ack = 1'b1;
        cycle(s);
        sample();
        check("ack_req_drop", 32'(miss_req_o), 32'd0);
        check("ack_resume_pc", pc_o, 32'h1234);

        // Bring bno to 3, miss, branch-miss while the fill is open.
        s = idle_in(); s.pt = 1'b1; s.ppc = 32'h1234;
        cycle(s);
        s = idle_in(); s.ihit = 1'b0;
        cycle(s);
        s = idle_in(); s.bm = 1'b1; s.misspc = 32'h8000;
        cycle(s);
        sample();
        check("mbm_stomp_bno", 32'(stomp_bno_o), 32'd3);
        check("mbm_bno", 32'(bno_o), 32'd4);
        check("mbm_req_held", 32'(miss_req_o), 32'd1);
        s = idle_in(); s.ack = 1'b1;
        cycle(s);
        sample();
        check("mbm_resume_pc", pc_o, 32'h8000);

        // Stall hold, then predicted redirect and bno wrap.
        s = idle_in(); s.stall = 1'b1;
        repeat (3) cycle(s);
        sample();
        check("stall_pc", pc_o, 32'h8000);
        check("stall_en", 32'(en_o), 32'd0);
        s = idle_in(); s.pt = 1'b1; s.ppc = 32'h4000;
        cycle(s);
        sample();
        check("pred_pc", pc_o, 32'h4000);
        check("pred_bno", 32'(bno_o), 32'd5);
        repeat (27) cycle(s);
        sample();
        check("bno_wrap", 32'(bno_o), 32'd1);

        // Interrupt latch.
        s = idle_in(); s.irq = 6'd5; s.lvl = 6'd2;
        cycle(s);
        sample();
        check("irq_set", 32'(irq_o), 32'd5);
        s.irq = 6'd7;
        cycle(s);
        sample();
        check("irq_raise", 32'(irq_o), 32'd7);
        s = idle_in(); s.iack = 1'b1;
        cycle(s);
        sample();
        check("irq_ack", 32'(irqf_o), 32'd0);
        s = idle_in(); s.mc = 1'b1; s.irq = 6'd5; s.lvl = 6'd2;
        cycle(s);
        sample();
        check("irq_mc_block", 32'(irqf_o), 32'd0);
        cycle(idle_in());

        repeat (1500) cycle(rand_in());

        // Drive into MISS, then assert reset between edges.
        s = idle_in(); s.ihit = 1'b0;
        for (int i = 0; i < 20 && m_mode != 2; i++) cycle(s);
        check("reach_miss", 32'(m_mode), 32'd2);
        sample();
        rst = 1'b0;
        #1;
        check("arst_miss_req", 32'(miss_req_o), 32'd0);
        check("arst_pc", pc_o, RSTPC);
        check("arst_rstcnt", 32'(rstcnt_o), 32'd0);
        model_reset();
        sample();
        rst = 1'b1;
        repeat (12) cycle(idle_in());

        repeat (3) sample();
        check("drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stark_fetch_ctrl.md
Name: stark_fetch_ctrl

Overview:
- Sequencer for the Stark fetch stage; produces the fetch PC, fetch-stage enable, reset count, stomp controls and interrupt flags consumed by the fetch pipeline register stage.
- Handles reset flush, sequential/predicted advance, branch-miss redirect, I-cache miss request/ack to the miss handler, downstream stall and micro-code hold.

Parameters:
- PCW, 32, PC width in bits.
- RSTPC, 32'hFFFD0000, reset fetch address.
- FETCH_INC, 20, bytes advanced per fetch group (5 instructions x 4 bytes).
- LINE_BYTES, 128, I-cache line size (1024-bit line).
- BNOW, 5, branch-number width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- ihit  in  1  I-cache hit for current pc_o
- stall_i  in  1  downstream back-pressure; hold fetch
- branchmiss_i  in  1  branch mispredict, one-cycle pulse
- misspc_i  in  PCW  corrected PC
- predict_taken_i  in  1  predictor says taken for current group
- predict_pc_i  in  PCW  predicted target
- mc_active_i  in  1  micro-code sequencer owns fetch address
- miss_ack_i  in  1  miss handler line fill complete
- irq_i  in  6  requested interrupt level
- irq_level_i  in  6  current mask level
- irq_ack_i  in  1  interrupt accepted by commit
- pc_o  out  PCW  fetch PC
- bno_o  out  BNOW  current branch number (bno_t)
- en_o  out  1  fetch-stage enable
- rstcnt_o  out  3  reset counter
- stomp_fet_o  out  1  stomp fetch group
- stomp_bno_o  out  BNOW  branch number being stomped
- miss_req_o  out  1  line fill request
- miss_adr_o  out  PCW  line-aligned miss address
- irq_o  out  6  latched interrupt level
- irqf_o  out  1  interrupt pending flag

Behaviour:
- Reset (rst=0, async): state RESET; pc_o=RSTPC; bno_o=1; rstcnt_o=0; en_o=1; stomp_fet_o=0; stomp_bno_o=0; miss_req_o=0; miss_adr_o=0; irq_o=0; irqf_o=0.
- RESET: rstcnt_o increments each cycle, saturates at 7; en_o=1 so fetch loads NOPs while rstcnt_o[2]=0; pc_o held. On rstcnt_o==7 the next state is RUN.
- RUN, priority highest first:
  1. branchmiss_i: pc_o<=misspc_i; stomp_fet_o=1 for one cycle; stomp_bno_o<=bno_o (old value); bno_o increments.
  2. mc_active_i: pc_o held.
  3. stall_i: en_o=0, pc_o held.
  4. !ihit: en_o=0; miss_req_o<=1; miss_adr_o<=pc_o & ~(LINE_BYTES-1); next state MISS.
  5. predict_taken_i: pc_o<=predict_pc_i; bno_o increments.
  6. Otherwise: pc_o<=pc_o+FETCH_INC.
- en_o in RUN = !stall_i && ihit, independent of branchmiss_i.
- bno_o increment: modulo 2^BNOW, skipping 0 (31 wraps to 1).
- pc_o arithmetic: modulo 2^PCW, no carry-out.
- MISS:
  - miss_req_o is held high until miss_ack_i is sampled; it drops on the next edge; then RUN.
  - en_o=0 throughout.
  - branchmiss_i during MISS: pc_o, stomp_fet_o, stomp_bno_o and bno_o update as in RUN; the request still completes; RUN resumes at the new pc_o. No second request is issued unless the new pc_o misses.
  - miss_ack_i outside MISS is ignored.
- Interrupts:
  - irqf_o sets when irq_i>irq_level_i and !mc_active_i; irq_o latches irq_i on set.
  - While irqf_o=1, a higher irq_i updates irq_o.
  - irq_ack_i clears irqf_o and irq_o next cycle. Ack has priority over a same-cycle set; a request still asserted re-sets irqf_o one cycle later.
- stomp_fet_o is a registered one-cycle pulse. Back-to-back branchmiss_i pulses give consecutive pulses with incrementing stomp_bno_o.
- Reset asserted mid-MISS aborts the handshake; miss_req_o=0 immediately.

Decomposition:
- Stark_pkg holds RSTPC, the FETCH_INC default, the fetch-state enum (RESET, RUN, MISS) and a bno_inc function (skip zero).
- One natural sub-module: stark_fetch_irq_latch (irqf_o/irq_o set/ack logic).

Test Plan:
- Reset release: rstcnt_o 0..7 over 7 cycles, en_o=1, pc_o=RSTPC; in RUN with ihit=1, pc_o=RSTPC+20, then +40.
- Miss: pc_o=0x1234 with ihit=0 -> miss_req_o=1, miss_adr_o=0x1200, en_o=0. miss_ack_i after 5 cycles -> req drops next edge; RUN resumes at 0x1234.
- Branchmiss during MISS: misspc_i=0x8000 with bno_o=3 -> stomp_fet_o one cycle, stomp_bno_o=3, bno_o=4. After ack, pc_o=0x8000.
- Stall plus predict: stall_i=1 holds pc_o and en_o=0. Release with predict_taken_i=1, predict_pc_i=0x4000 -> pc_o=0x4000, bno_o+1. bno_o=31 wraps to 1.
- IRQ: irq_level_i=2, irq_i=5 -> irqf_o=1, irq_o=5. irq_i=7 -> irq_o=7. irq_ack_i -> both 0. mc_active_i=1 blocks the set.
- Async reset asserted mid-MISS -> miss_req_o=0, state RESET, pc_o=RSTPC without a clock edge.
